multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle RV32I core. Sequences the shared ALU, PC, IR, register file and unified memory
//  over FETCH/DECODE/EXECUTE/MEM/WB steps. Drives alu_op into alu_decoder and all datapath mux/enable controls.
//  Supports lw, sw, R-type, I-type ALU, beq and jal. Memory accesses use a req/ready handshake.
// PARAMETERS
//  MEM_WAIT_EN  1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready treated as 1
//  STATE_W      4  state register width (fits 11 states)
// PORTS
//  clk          in   1  core clock, all state on rising edge
//  reset        in   1  asynchronous, active-high
//  op           in   7  instr[6:0] from IR
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory completes current access this cycle
//  mem_req      out  1  memory access requested
//  mem_write    out  1  access is a store
//  adr_src      out  1  0: PC, 1: ALUOut
//  ir_write     out  1  load IR and OldPC
//  pc_write     out  1  = pc_update | (branch & zero)
//  reg_write    out  1  register file write enable
//  alu_src_a    out  2  00 PC, 01 OldPC, 10 rs1
//  alu_src_b    out  2  00 rs2, 01 imm, 10 const 4
//  result_src   out  2  00 ALUOut, 01 Data, 10 ALU result
//  imm_src      out  2  00 I, 01 S, 10 B, 11 J (comb. from op)
//  alu_op       out  2  to alu_decoder (see timing)
//  illegal_op   out  1  one-cycle pulse on unsupported opcode
//  state_dbg    out  STATE_W  current state
// BEHAVIOUR
//  Reset (async): state<=FETCH. While reset=1, mem_req/mem_write/ir_write/pc_write/reg_write/illegal_op=0,
//   alu_op=00, mux selects hold FETCH values. First fetch starts the cycle after reset deasserts.
//  alu_op is derived combinationally from next_state, because alu_decoder registers alu_control, so alu_control is valid
//   throughout the state that needs it. All other outputs are Moore decodes of the current state.
//  FETCH    : mem_req, adr_src=0, srcA=00, srcB=10, result_src=10. Stays until mem_ready.
//             On mem_ready: ir_write=1, pc_update=1, then -> DECODE.
//  DECODE   : srcA=01, srcB=01, alu_op=00 (branch target into ALUOut).
//             Next state by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ,
//             1101111->JAL. Any other op: illegal_op=1 and -> FETCH.
//  MEMADR   : srcA=10, srcB=01, alu_op=00. op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
//  MEMREAD  : mem_req, adr_src=1. Waits for mem_ready, then -> MEMWB.
//  MEMWB    : result_src=01, reg_write=1 -> FETCH.
//  MEMWRITE : mem_req, mem_write, adr_src=1. Waits for mem_ready, then -> FETCH.
//             mem_write stays asserted for every wait cycle.
//  EXECR    : srcA=10, srcB=00, alu_op=10 -> ALUWB.
//  EXECI    : srcA=10, srcB=01, alu_op=10 -> ALUWB.
//  ALUWB    : result_src=00, reg_write=1 -> FETCH.
//  BEQ      : srcA=10, srcB=00, alu_op=01, result_src=00, branch=1 -> FETCH. pc_write=zero.
//  JAL      : srcA=01, srcB=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB (rd=PC+4).
//  Zero-wait latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
//   Each mem_ready=0 cycle adds exactly 1 cycle to that instruction.
//  mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE. zero is ignored outside BEQ.
//  Reset mid-instruction: the instruction is abandoned. Nothing is written after reset asserts; fetch restarts.
//  Unused state encodings -> FETCH with all enables 0.
// STRUCTURE
//  Shared header ctrl_defs.vh: state encodings, opcode localparams, ALU_OP_*, SRC_A_*, SRC_B_*, RES_*, IMM_*.
//  One sub-module: imm_src_decoder (op -> imm_src, combinational). FSM, next-state and output decode stay in one file.
// TESTING
//  1 R-type add, mem_ready=1: states FETCH,DECODE,EXECR,ALUWB. alu_op seen by alu_decoder = 00,00,10,00.
//    reg_write=1 only in cycle 4.
//  2 lw with mem_ready low 2 cycles in MEMREAD: 7 cycles total. mem_req held in MEMREAD. MEMWB has result_src=01.
//  3 beq: zero=1 gives pc_write=1 in BEQ. zero=0 gives pc_write=0 and 3 cycles total.
//    zero toggled in other states has no effect.
//  4 jal: pc_write in JAL, then ALUWB with reg_write=1 and result_src=00. imm_src=11 throughout.
//  5 op=0000000 in DECODE: illegal_op pulses for 1 cycle, next state FETCH, no reg_write or mem_write.
//  6 reset asserted mid-MEMWRITE with mem_ready=0: mem_write drops immediately and state is FETCH.
//    After release, first ir_write follows mem_ready.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // alu_decoder registers its control, so the operation is chosen by the state being entered.
    function automatic logic [1:0] alu_op_for(input state_e s);
        case (s)
            S_EXECR, S_EXECI: alu_op_for = ALU_OP_FUNCT;
            S_BEQ:            alu_op_for = ALU_OP_SUB;
            default:          alu_op_for = ALU_OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Immediate format select, decoded combinationally from the opcode in IR.
module imm_src_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback over the shared ALU and unified memory.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         imm_src,
    output logic [1:0]         alu_op,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_e     state_q;
    state_e     state_d;
    logic       ready;
    logic       mem_req_c;
    logic       mem_write_c;
    logic       adr_src_c;
    logic       ir_write_c;
    logic       pc_update_c;
    logic       branch_c;
    logic       reg_write_c;
    logic       illegal_c;
    logic [1:0] src_a_c;
    logic [1:0] src_b_c;
    logic [1:0] result_c;

    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        adr_src_c   = 1'b0;
        ir_write_c  = 1'b0;
        pc_update_c = 1'b0;
        branch_c    = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        src_a_c     = SRC_A_PC;
        src_b_c     = SRC_B_RS2;
        result_c    = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src_b_c   = SRC_B_FOUR;
                result_c  = RES_ALU;
                if (ready) begin
                    ir_write_c  = 1'b1;
                    pc_update_c = 1'b1;
                    state_d     = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is computed here so BEQ can take it from ALUOut.
                src_a_c = SRC_A_OLDPC;
                src_b_c = SRC_B_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_c = SRC_A_RS1;
                src_b_c = SRC_B_IMM;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                state_d   = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_c    = RES_DATA;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                state_d     = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                src_a_c = SRC_A_RS1;
                src_b_c = SRC_B_RS2;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c = SRC_A_RS1;
                src_b_c = SRC_B_IMM;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                result_c    = RES_ALUOUT;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                src_a_c  = SRC_A_RS1;
                src_b_c  = SRC_B_RS2;
                result_c = RES_ALUOUT;
                branch_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
                src_a_c     = SRC_A_OLDPC;
                src_b_c     = SRC_B_FOUR;
                result_c    = RES_ALUOUT;
                pc_update_c = 1'b1;
                state_d     = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Enables are masked during reset since the async reset parks the FSM in FETCH.
    assign mem_req    = mem_req_c & ~reset;
    assign mem_write  = mem_write_c & ~reset;
    assign adr_src    = adr_src_c;
    assign ir_write   = ir_write_c & ~reset;
    assign pc_write   = (pc_update_c | (branch_c & zero)) & ~reset;
    assign reg_write  = reg_write_c & ~reset;
    assign illegal_op = illegal_c & ~reset;
    assign alu_src_a  = src_a_c;
    assign alu_src_b  = src_b_c;
    assign result_src = result_c;
    assign alu_op     = reset ? ALU_OP_ADD : alu_op_for(state_d);
    assign state_dbg  = STATE_W'(state_q);

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (imm_src)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: instructions are modelled as step
// sequences, memory waits and the zero flag are randomized per cycle.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    typedef enum int {T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB, T_B, T_J} step_t;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_op;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, alu_op;
    logic [3:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_controller #(.MEM_WAIT_EN(1), .STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_op     (alu_op),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] state_of(input step_t s);
        case (s)
            T_F:     return S_FETCH;
            T_D:     return S_DECODE;
            T_MA:    return S_MEMADR;
            T_MR:    return S_MEMREAD;
            T_MWB:   return S_MEMWB;
            T_MW:    return S_MEMWRITE;
            T_ER:    return S_EXECR;
            T_EI:    return S_EXECI;
            T_AWB:   return S_ALUWB;
            T_B:     return S_BEQ;
            default: return S_JAL;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
               (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Compare every output against what the current step requires.
    task automatic check_step(input step_t st, input step_t nxt, input bit rdy, input bit z,
                              input bit ill, input logic [6:0] o);
        logic [1:0] ea, eb, er, eop;
        ea  = (st == T_D || st == T_J) ? 2'b01 :
              (st == T_MA || st == T_ER || st == T_EI || st == T_B) ? 2'b10 : 2'b00;
        eb  = (st == T_F || st == T_J) ? 2'b10 :
              (st == T_D || st == T_MA || st == T_EI) ? 2'b01 : 2'b00;
        er  = (st == T_F) ? 2'b10 : (st == T_MWB) ? 2'b01 : 2'b00;
        eop = (nxt == T_ER || nxt == T_EI) ? 2'b10 : (nxt == T_B) ? 2'b01 : 2'b00;
        check("state",      32'(state_dbg),  32'(state_of(st)));
        check("mem_req",    32'(mem_req),    32'(st == T_F || st == T_MR || st == T_MW));
        check("mem_write",  32'(mem_write),  32'(st == T_MW));
        check("adr_src",    32'(adr_src),    32'(st == T_MR || st == T_MW));
        check("ir_write",   32'(ir_write),   32'(st == T_F && rdy));
        check("pc_write",   32'(pc_write),   32'((st == T_F && rdy) || st == T_J || (st == T_B && z)));
        check("reg_write",  32'(reg_write),  32'(st == T_MWB || st == T_AWB));
        check("alu_src_a",  32'(alu_src_a),  32'(ea));
        check("alu_src_b",  32'(alu_src_b),  32'(eb));
        check("result_src", 32'(result_src), 32'(er));
        check("imm_src",    32'(imm_src),    32'(exp_imm(o)));
        check("alu_op",     32'(alu_op),     32'(eop));
        check("illegal_op", 32'(illegal_op), 32'(st == T_D && ill));
    endtask

    // cls: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal (iop).
    // fwait/mwait: exact wait cycles in fetch / memory access, -1 = random.
    // zmode: zero value held in BEQ, -1 = random.
    task automatic run_instr(input int cls, input int fwait, input int mwait,
                             input int zmode, input logic [6:0] iop);
        step_t      seq[$];
        logic [6:0] opv;
        int         idx, waits, lim;
        step_t      st, nxt;
        bit         waitable, rdy, adv, z;
        seq.push_back(T_F);
        seq.push_back(T_D);
        case (cls)
            0: begin opv = 7'b0000011; seq.push_back(T_MA); seq.push_back(T_MR); seq.push_back(T_MWB); end
            1: begin opv = 7'b0100011; seq.push_back(T_MA); seq.push_back(T_MW); end
            2: begin opv = 7'b0110011; seq.push_back(T_ER); seq.push_back(T_AWB); end
            3: begin opv = 7'b0010011; seq.push_back(T_EI); seq.push_back(T_AWB); end
            4: begin opv = 7'b1100011; seq.push_back(T_B); end
            5: begin opv = 7'b1101111; seq.push_back(T_J); seq.push_back(T_AWB); end
            default: opv = iop;
        endcase
        idx   = 0;
        waits = 0;
        while (idx < seq.size()) begin
            st       = seq[idx];
            waitable = (st == T_F || st == T_MR || st == T_MW);
            lim      = (st == T_F) ? fwait : mwait;
            @(negedge clk);
            z = 1'($urandom);
            if (st == T_B && zmode >= 0) z = 1'(zmode);
            if (!waitable)     rdy = 1'($urandom);
            else if (lim < 0)  rdy = (waits >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            else               rdy = (waits >= lim);
            op        = opv;
            zero      = z;
            mem_ready = rdy;
            adv       = !waitable || rdy;
            nxt       = !adv ? st : (idx + 1 < seq.size()) ? seq[idx + 1] : T_F;
            #1;
            check_step(st, nxt, rdy, z, cls == 6, opv);
            if (adv) begin
                idx++;
                waits = 0;
            end else begin
                waits++;
            end
        end
    endtask

    initial begin
        logic [6:0] rop;
        reset     = 1'b1;
        op        = 7'b0110011;
        zero      = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state",     32'(state_dbg),  32'(S_FETCH));
        check("rst_mem_req",   32'(mem_req),    32'h0);
        check("rst_ir_write",  32'(ir_write),   32'h0);
        check("rst_pc_write",  32'(pc_write),   32'h0);
        check("rst_reg_write", 32'(reg_write),  32'h0);
        check("rst_illegal",   32'(illegal_op), 32'h0);
        check("rst_alu_op",    32'(alu_op),     32'h0);
        check("rst_src_b",     32'(alu_src_b),  32'h2);
        check("rst_result",    32'(result_src), 32'h2);
        mem_ready = 1'b0;
        reset     = 1'b0;

        run_instr(2, 0, 0, -1, 7'h0);
        run_instr(0, 0, 2, -1, 7'h0);
        run_instr(1, 1, 3, -1, 7'h0);
        run_instr(4, 0, 0, 1, 7'h0);
        run_instr(4, 0, 0, 0, 7'h0);
        run_instr(5, 0, 0, -1, 7'h0);
        run_instr(6, 0, 0, -1, 7'h00);
        run_instr(3, 2, 0, -1, 7'h0);

        for (int i = 0; i < 80; i++) begin
            int cls;
            cls = $urandom_range(0, 6);
            rop = 7'($urandom);
            for (int k = 0; k < 8 && is_legal(rop); k++) rop = 7'($urandom);
            if (is_legal(rop)) rop = 7'h7f;
            run_instr(cls, -1, -1, -1, rop);
        end

        // Store abandoned by reset while the memory is stalling.
        @(negedge clk); op = 7'b0100011; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        check("sw_wait_state", 32'(state_dbg), 32'(S_MEMWRITE));
        check("sw_wait_mw",    32'(mem_write), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rst_mw_drop",    32'(mem_write), 32'h0);
        check("rst_mreq_drop",  32'(mem_req),   32'h0);
        check("rst_mw_state",   32'(state_dbg), 32'(S_FETCH));
        check("rst_mw_regw",    32'(reg_write), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_state",      32'(state_dbg), 32'(S_FETCH));
        check("rel_ir_nowait",  32'(ir_write),  32'h0);
        @(negedge clk); mem_ready = 1'b0;
        #1;
        check("rel_hold_state", 32'(state_dbg), 32'(S_FETCH));
        check("rel_hold_ir",    32'(ir_write),  32'h0);
        @(negedge clk); mem_ready = 1'b1;
        #1;
        check("rel_ir_write",   32'(ir_write),  32'h1);
        check("rel_pc_write",   32'(pc_write),  32'h1);
        @(negedge clk);
        #1;
        check("rel_decode",     32'(state_dbg), 32'(S_DECODE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
